// File: rtl/iob_timer_mc.sv
// iob_timer_mc: N_CH down-counting timers with prescalers behind a one-cycle valid/ready bus.
// Define IOB_TIMER_MC_IRQ_EN to build the per-channel IE bits and the irq output.
module iob_timer_mc #(
  parameter int unsigned N_CH   = 2,
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                iob_valid,
  input  logic [ADDR_W-1:0]   iob_addr,
  input  logic [DATA_W-1:0]   iob_wdata,
  input  logic [DATA_W/8-1:0] iob_wstrb,
  output logic [DATA_W-1:0]   iob_rdata,
  output logic                iob_ready,
  output logic                irq
);

  localparam logic [1:0] RegCtrl   = 2'd0;
  localparam logic [1:0] RegLoad   = 2'd1;
  localparam logic [1:0] RegValue  = 2'd2;
  localparam logic [15:0]      PcntOne = 16'd1;
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  logic [N_CH-1:0]             en_q, en_d, mode_q, mode_d, exp_q, exp_d;
  logic [N_CH-1:0][15:0]       presc_q, presc_d, pcnt_q, pcnt_d;
  logic [N_CH-1:0][CNT_W-1:0]  load_q, load_d, value_q, value_d;
  logic [N_CH-1:0]             ie_rd, tick, ch_wr;
  logic [DATA_W-1:0]           rdata_q, rd_word;
  logic                        ready_q;
  logic                        wr, rd;
  int unsigned                 ch_sel;
  logic [1:0]                  reg_sel;
  logic                        unused_bits;

  assign wr          = iob_valid & (|iob_wstrb);
  assign rd          = iob_valid & ~(|iob_wstrb);
  assign ch_sel      = 32'(iob_addr) >> 2;
  assign reg_sel     = iob_addr[1:0];
  assign iob_rdata   = rdata_q;
  assign iob_ready   = ready_q;
  assign unused_bits = ^iob_wdata;

`ifdef IOB_TIMER_MC_IRQ_EN
  logic [N_CH-1:0] ie_q, ie_d;
  logic            irq_q;

  assign ie_rd = ie_q;
  assign irq   = irq_q;

  always_comb begin
    ie_d = ie_q;
    for (int unsigned c = 0; c < N_CH; c++) begin
      if (ch_wr[c] && reg_sel == RegCtrl) ie_d[c] = iob_wdata[2];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ie_q  <= '0;
      irq_q <= 1'b0;
    end else begin
      ie_q  <= ie_d;
      irq_q <= |(exp_q & ie_q);
    end
  end
`else
  assign ie_rd = '0;
  assign irq   = 1'b0;
`endif

  always_comb begin
    for (int unsigned c = 0; c < N_CH; c++) begin
      ch_wr[c] = wr && (ch_sel == c);
      // >= keeps the prescaler from running away if PRESC shrinks mid-count
      tick[c]  = en_q[c] && (pcnt_q[c] >= presc_q[c]);
    end
  end

  always_comb begin
    en_d    = en_q;
    mode_d  = mode_q;
    exp_d   = exp_q;
    presc_d = presc_q;
    pcnt_d  = pcnt_q;
    load_d  = load_q;
    value_d = value_q;
    for (int unsigned c = 0; c < N_CH; c++) begin
      if (en_q[c]) pcnt_d[c] = tick[c] ? '0 : pcnt_q[c] + PcntOne;
      else         pcnt_d[c] = '0;

      // Clear first so a same-cycle expiry below wins.
      if (ch_wr[c] && reg_sel == 2'd3 && iob_wdata[0]) exp_d[c] = 1'b0;

      if (tick[c]) begin
        if (value_q[c] != '0) begin
          value_d[c] = value_q[c] - CntOne;
        end else begin
          exp_d[c] = 1'b1;
          if (mode_q[c]) en_d[c] = 1'b0;
          else           value_d[c] = load_q[c];
        end
      end

      if (ch_wr[c] && reg_sel == RegCtrl) begin
        en_d[c]    = iob_wdata[0];
        mode_d[c]  = iob_wdata[1];
        presc_d[c] = iob_wdata[31:16];
        if (!iob_wdata[0]) pcnt_d[c] = '0;
        if (!en_q[c] && iob_wdata[0]) begin
          value_d[c] = load_q[c];
          pcnt_d[c]  = '0;
        end
      end

      if (ch_wr[c] && reg_sel == RegLoad) load_d[c] = iob_wdata[CNT_W-1:0];
    end
  end

  always_comb begin
    rd_word = '0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      if (ch_sel == c) begin
        case (reg_sel)
          RegCtrl:  rd_word = {presc_q[c], 13'd0, ie_rd[c], mode_q[c], en_q[c]};
          RegLoad:  rd_word = DATA_W'(load_q[c]);
          RegValue: rd_word = DATA_W'(value_q[c]);
          default:  rd_word = {31'd0, exp_q[c]};
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_q    <= '0;
      mode_q  <= '0;
      exp_q   <= '0;
      presc_q <= '0;
      pcnt_q  <= '0;
      load_q  <= '0;
      value_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
    end else begin
      en_q    <= en_d;
      mode_q  <= mode_d;
      exp_q   <= exp_d;
      presc_q <= presc_d;
      pcnt_q  <= pcnt_d;
      load_q  <= load_d;
      value_q <= value_d;
      rdata_q <= rd ? rd_word : '0;
      ready_q <= iob_valid;
    end
  end

endmodule

// File: tb/tb_iob_timer_mc.sv
// Self-checking bench for iob_timer_mc: directed scenarios plus randomized channel runs
// checked against a closed-form tick-count model.
module tb_iob_timer_mc;

  localparam int NCh = 2;
  localparam bit IrqBuild =
`ifdef IOB_TIMER_MC_IRQ_EN
    1'b1;
`else
    1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        iob_valid;
  logic [4:0]  iob_addr;
  logic [31:0] iob_wdata;
  logic [3:0]  iob_wstrb;
  logic [31:0] iob_rdata;
  logic        iob_ready;
  logic        irq;

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int e_last;

  iob_timer_mc dut (
    .clk       (clk),
    .rst       (rst),
    .iob_valid (iob_valid),
    .iob_addr  (iob_addr),
    .iob_wdata (iob_wdata),
    .iob_wstrb (iob_wstrb),
    .iob_rdata (iob_rdata),
    .iob_ready (iob_ready),
    .irq       (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [4:0] a(input int c, input int r);
    return 5'(4 * c + r);
  endfunction

  // Ticks seen by a read captured at edge r, for a channel enabled at edge e.
  function automatic int ticks(input int p, input int e, input int r);
    return (r - 1 - e) / (p + 1);
  endfunction

  function automatic logic [31:0] m_value(input int l, input int p, input bit os,
                                          input int e, input int r);
    int k = ticks(p, e, r);
    if (os && k >= l + 1) return 32'd0;
    return 32'(l - (k % (l + 1)));
  endfunction

  function automatic logic [31:0] m_exp(input int l, input int p, input int e, input int r);
    return (ticks(p, e, r) >= l + 1) ? 32'd1 : 32'd0;
  endfunction

  function automatic logic [31:0] m_ctrl(input int p, input bit ie, input bit os, input bit en);
    return {16'(p), 13'd0, ie, os, en};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got=%h expected=%h", tag, got, want);
    end
  endtask

  task automatic bus_write(input logic [4:0] addr, input logic [31:0] data);
    @(negedge clk);
    iob_valid = 1'b1;
    iob_addr  = addr;
    iob_wdata = data;
    iob_wstrb = 4'hF;
    @(posedge clk);
    #1;
    e_last    = cyc;
    iob_valid = 1'b0;
    iob_wstrb = 4'h0;
  endtask

  task automatic bus_read(input logic [4:0] addr, output logic [31:0] data);
    @(negedge clk);
    iob_valid = 1'b1;
    iob_addr  = addr;
    iob_wstrb = 4'h0;
    @(posedge clk);
    #1;
    e_last    = cyc;
    iob_valid = 1'b0;
    data      = iob_rdata;
    check("rd_ready", 32'(iob_ready), 32'd1);
  endtask

  task automatic wait_edge(input int r);
    while (cyc < r - 1) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [31:0] d;
    int e, l, p, c;
    bit os;

    rst = 1'b0; iob_valid = 1'b0; iob_addr = '0; iob_wdata = '0; iob_wstrb = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(iob_ready), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_rdata", iob_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int ch = 0; ch < NCh; ch++) begin
      for (int r = 0; r < 4; r++) begin
        bus_read(a(ch, r), d);
        check($sformatf("rst_reg_c%0d_r%0d", ch, r), d, 32'd0);
      end
    end

    // ch0 periodic LOAD=3, PRESC=0, VALUE read back-to-back
    bus_write(a(0, 1), 32'd3);
    bus_write(a(0, 0), 32'h1);
    e = e_last;
    @(negedge clk);
    iob_valid = 1'b1; iob_addr = a(0, 2); iob_wstrb = 4'h0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check("b2b_ready", 32'(iob_ready), 32'd1);
      check($sformatf("periodic_value_%0d", i), iob_rdata, m_value(3, 0, 1'b0, e, cyc));
    end
    iob_valid = 1'b0;
    bus_read(a(0, 3), d);
    check("periodic_exp", d, m_exp(3, 0, e, e_last));
    bus_write(a(0, 0), 32'h0);

    // ch1 one-shot LOAD=2, PRESC=4: expiry 15 cycles after enable
    bus_write(a(1, 1), 32'd2);
    bus_write(a(1, 0), 32'h0004_0003);
    e = e_last;
    wait_edge(e + 15);
    bus_read(a(1, 3), d);
    check("oneshot_exp_before", d, m_exp(2, 4, e, e_last));
    bus_read(a(1, 3), d);
    check("oneshot_exp_after", d, m_exp(2, 4, e, e_last));
    wait_edge(e + 30);
    bus_read(a(1, 0), d);
    check("oneshot_ctrl", d, m_ctrl(4, 1'b0, 1'b1, 1'b0));
    bus_read(a(1, 2), d);
    check("oneshot_value", d, m_value(2, 4, 1'b1, e, e_last));

    // ch1 expiring every cycle: W1C loses to a coincident expiry
    bus_write(a(1, 1), 32'd0);
    bus_write(a(1, 0), 32'h1);
    bus_write(a(1, 3), 32'h1);
    bus_read(a(1, 3), d);
    check("w1c_vs_expiry", d, 32'd1);
    bus_write(a(1, 0), 32'h0);
    bus_write(a(1, 3), 32'h1);
    bus_read(a(1, 3), d);
    check("w1c_clears", d, 32'd0);

    // ch0 one-shot LOAD=0 with IE=1: irq follows EXP by one cycle
    bus_write(a(0, 3), 32'h1);
    bus_write(a(0, 1), 32'd0);
    bus_write(a(0, 0), 32'h7);
    check("irq_at_enable", 32'(irq), 32'd0);
    @(posedge clk); #1;
    check("irq_expiry_cycle", 32'(irq), 32'd0);
    @(posedge clk); #1;
    check("irq_raise", 32'(irq), 32'(IrqBuild));
    bus_read(a(0, 0), d);
    check("irq_ctrl", d, m_ctrl(0, IrqBuild, 1'b1, 1'b0));
    bus_read(a(0, 3), d);
    check("irq_exp", d, 32'd1);
    bus_write(a(0, 3), 32'h1);
    check("irq_hold_after_clear", 32'(irq), 32'(IrqBuild));
    @(posedge clk); #1;
    check("irq_drop", 32'(irq), 32'd0);
    bus_read(a(0, 3), d);
    check("irq_exp_cleared", d, 32'd0);

    // Unmapped accesses and read-only VALUE
    @(posedge clk); #1;
    check("idle_ready", 32'(iob_ready), 32'd0);
    bus_read(5'(4 * NCh), d);
    check("unmapped_rdata", d, 32'd0);
    @(posedge clk); #1;
    check("ready_one_cycle", 32'(iob_ready), 32'd0);
    bus_write(a(0, 2), 32'hFF);
    bus_read(a(0, 2), d);
    check("value_readonly", d, 32'd0);
    bus_write(5'(4 * NCh), 32'hFFFF_FFFF);
    bus_read(a(0, 0), d);
    check("unmapped_wr_ctrl", d, m_ctrl(0, IrqBuild, 1'b1, 1'b0));
    bus_read(a(0, 1), d);
    check("unmapped_wr_load", d, 32'd0);

    // Randomized channel runs against the closed-form model
    for (int it = 0; it < 12; it++) begin
      c  = int'($urandom_range(0, NCh - 1));
      l  = int'($urandom_range(0, 6));
      p  = int'($urandom_range(0, 3));
      os = 1'($urandom_range(0, 1));
      bus_write(a(c, 0), 32'h0);
      bus_write(a(c, 3), 32'h1);
      bus_write(a(c, 1), 32'(l));
      bus_write(a(c, 0), m_ctrl(p, 1'b0, os, 1'b1));
      e = e_last;
      repeat ($urandom_range(0, 25)) @(posedge clk);
      #1;
      bus_read(a(c, 2), d);
      check($sformatf("rnd%0d_value", it), d, m_value(l, p, os, e, e_last));
      bus_read(a(c, 3), d);
      check($sformatf("rnd%0d_exp", it), d, m_exp(l, p, e, e_last));
      bus_read(a(c, 0), d);
      check($sformatf("rnd%0d_ctrl", it), d,
            m_ctrl(p, 1'b0, os, !(os && ticks(p, e, e_last) >= l + 1)));
    end

    // Reset asserted mid-count and mid-transaction
    bus_write(a(0, 1), 32'd10);
    bus_write(a(0, 0), 32'h0);
    bus_write(a(0, 0), 32'h1);
    e = e_last;
    repeat (5) @(posedge clk);
    @(negedge clk);
    iob_valid = 1'b1; iob_addr = a(0, 2); iob_wstrb = 4'h0;
    @(posedge clk);
    #1;
    check("pre_rst_rdata", iob_rdata, m_value(10, 0, 1'b0, e, cyc));
    #1;
    rst = 1'b0;
    #1;
    check("async_rst_ready", 32'(iob_ready), 32'd0);
    check("async_rst_rdata", iob_rdata, 32'd0);
    check("async_rst_irq", 32'(irq), 32'd0);
    iob_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int ch = 0; ch < NCh; ch++) begin
      for (int r = 0; r < 4; r++) begin
        bus_read(a(ch, r), d);
        check($sformatf("post_rst_c%0d_r%0d", ch, r), d, 32'd0);
      end
    end
    repeat (20) @(posedge clk);
    #1;
    check("post_rst_irq", 32'(irq), 32'd0);
    bus_read(a(0, 2), d);
    check("post_rst_idle_value", d, 32'd0);
    bus_read(a(0, 3), d);
    check("post_rst_idle_exp", d, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
